// File: rtl/fir_16_tap_axis_pkg.sv
// Shared constants, FSM state type and coefficient defaults for the 16-tap FIR.
package fir_pkg;

  localparam int TAPS      = 16;
  localparam int DATA_W    = 16;
  localparam int COEFF_W   = 16;
  localparam int NUM_BANKS = 4;
  localparam int FRAC_BITS = 15;
  localparam int TAP_W     = $clog2(TAPS);
  localparam int BANK_W    = $clog2(NUM_BANKS);
  // Full product plus log2(TAPS) guard bits so a 16-term sum never wraps.
  localparam int ACC_W     = DATA_W + COEFF_W + TAP_W;

  localparam logic [COEFF_W-1:0] COEFF_PASS  = 16'h7FFF;
  localparam logic [COEFF_W-1:0] COEFF_AVG16 = 16'h0800;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } fir_state_t;

  typedef struct packed {
    logic [BANK_W-1:0]  bank;
    logic [TAP_W-1:0]   tap;
    logic [COEFF_W-1:0] value;
  } coeff_wr_t;

  // Bank 0 passes the newest sample through; the other banks average all taps.
  function automatic logic [COEFF_W-1:0] coeff_default(input int bank, input int tap);
    if (bank == 0) begin
      return (tap == 0) ? COEFF_PASS : '0;
    end
    return COEFF_AVG16;
  endfunction

endpackage

// File: rtl/fir_16_tap_axis_if.sv
// Sample, result and coefficient-update signals of one FIR axis.
interface fir_16_tap_axis_if;
  import fir_pkg::*;

  // Handshake: no back-pressure. sample_valid is a one-cycle strobe taken only in
  // IDLE (otherwise dropped and flagged via overrun); result_valid is a one-cycle
  // strobe and result_out holds between strobes; update_en is a level whose
  // rising edge requests exactly one coefficient write.
  logic               sample_valid;
  logic [DATA_W-1:0]  sample_in;
  logic [BANK_W-1:0]  bank_sel;
  logic               update_en;
  logic [BANK_W-1:0]  update_bank;
  logic [TAP_W-1:0]   update_index;
  logic [COEFF_W-1:0] update_value;
  logic [DATA_W-1:0]  result_out;
  logic               result_valid;
  logic               busy;
  logic               overrun;

  modport master (
    output sample_valid, sample_in, bank_sel,
    output update_en, update_bank, update_index, update_value,
    input  result_out, result_valid, busy, overrun
  );

  modport slave (
    input  sample_valid, sample_in, bank_sel,
    input  update_en, update_bank, update_index, update_value,
    output result_out, result_valid, busy, overrun
  );

endinterface

// File: rtl/fir_16_tap_axis_coeff_bank.sv
// Coefficient register file: one synchronous write port, one combinational read port.
module fir_coeff_bank
  import fir_pkg::*;
(
  input  logic               sys_clk,
  input  logic               reset,
  input  logic               we_i,
  input  logic [BANK_W-1:0]  wr_bank_i,
  input  logic [TAP_W-1:0]   wr_tap_i,
  input  logic [COEFF_W-1:0] wr_data_i,
  input  logic [BANK_W-1:0]  rd_bank_i,
  input  logic [TAP_W-1:0]   rd_tap_i,
  output logic [COEFF_W-1:0] rd_data_o
);

  logic [COEFF_W-1:0] coeff_q [NUM_BANKS][TAPS];

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        for (int t = 0; t < TAPS; t++) begin
          coeff_q[b][t] <= coeff_default(b, t);
        end
      end
    end else if (we_i) begin
      coeff_q[wr_bank_i][wr_tap_i] <= wr_data_i;
    end
  end

  assign rd_data_o = coeff_q[rd_bank_i][rd_tap_i];

endmodule

// File: rtl/fir_16_tap_axis.sv
// One-axis 16-tap FIR with a single serial MAC, four coefficient banks and a
// deferred coefficient-update port.
module fir_16_tap_axis
  import fir_pkg::*;
(
  input  logic             sys_clk,
  input  logic             reset,
  fir_16_tap_axis_if.slave bus,
  output fir_state_t       state_o
);

  localparam int PROD_W = DATA_W + COEFF_W;
  localparam int RES_W  = ACC_W - FRAC_BITS;
  localparam logic [ACC_W-1:0] ROUND_HALF =
    {{(ACC_W - FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS - 1){1'b0}}};

  fir_state_t state_q, state_d;

  logic [DATA_W-1:0]  delay_q [TAPS];
  logic [BANK_W-1:0]  bank_q;
  logic [TAP_W-1:0]   tap_q;
  logic [ACC_W-1:0]   acc_q;
  logic [DATA_W-1:0]  result_q;
  logic               result_valid_q;
  logic               overrun_q;
  logic               upd_en_q;
  coeff_wr_t          pend_q;
  logic               pend_valid_q;

  logic               accept;
  logic               mac_en;
  logic               mac_done;
  logic               wr_en;
  logic               busy;
  logic               last_tap;
  logic               upd_edge;
  logic [COEFF_W-1:0] coeff_rd;
  logic [PROD_W-1:0]  product;
  logic [ACC_W-1:0]   acc_sum;
  logic [ACC_W-1:0]   rounded;
  logic [RES_W-1:0]   shifted;
  logic [RES_W-DATA_W:0] high_bits;
  logic [DATA_W-1:0]  result_d;

  // ---------------- FSM ----------------
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.sample_valid) state_d = MAC;
      MAC:     if (last_tap)         state_d = OUT;
      OUT:                           state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  always_comb begin
    accept   = 1'b0;
    mac_en   = 1'b0;
    wr_en    = 1'b0;
    busy     = 1'b1;
    case (state_q)
      IDLE: begin
        accept = bus.sample_valid;
        wr_en  = pend_valid_q;
        busy   = 1'b0;
      end
      MAC:     mac_en = 1'b1;
      default: ;
    endcase
  end

  assign last_tap = (tap_q == TAP_W'(TAPS - 1));
  assign mac_done = mac_en & last_tap;
  assign upd_edge = bus.update_en & ~upd_en_q;

  // ---------------- Coefficients ----------------
  fir_coeff_bank u_coeff (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .we_i      (wr_en),
    .wr_bank_i (pend_q.bank),
    .wr_tap_i  (pend_q.tap),
    .wr_data_i (pend_q.value),
    .rd_bank_i (bank_q),
    .rd_tap_i  (tap_q),
    .rd_data_o (coeff_rd)
  );

  // ---------------- MAC datapath ----------------
  always_comb begin
    product = $signed({{COEFF_W{delay_q[tap_q][DATA_W-1]}}, delay_q[tap_q]}) *
              $signed({{DATA_W{coeff_rd[COEFF_W-1]}}, coeff_rd});
    acc_sum = acc_q + {{TAP_W{product[PROD_W-1]}}, product};
    // Round half up, then keep the integer part (arithmetic shift by FRAC_BITS).
    rounded   = acc_sum + ROUND_HALF;
    shifted   = rounded[ACC_W-1:FRAC_BITS];
    high_bits = shifted[RES_W-1:DATA_W-1];
    if ((&high_bits) || !(|high_bits)) begin
      result_d = shifted[DATA_W-1:0];
    end else if (shifted[RES_W-1]) begin
      result_d = {1'b1, {(DATA_W - 1){1'b0}}};
    end else begin
      result_d = {1'b0, {(DATA_W - 1){1'b1}}};
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) delay_q[i] <= '0;
      bank_q         <= '0;
      tap_q          <= '0;
      acc_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      if (accept) begin
        for (int i = TAPS - 1; i > 0; i--) delay_q[i] <= delay_q[i-1];
        delay_q[0] <= bus.sample_in;
        bank_q     <= bus.bank_sel;
        tap_q      <= '0;
        acc_q      <= '0;
      end else if (mac_en) begin
        tap_q <= tap_q + TAP_W'(1);
        acc_q <= acc_sum;
      end
      // The final sum is rounded on the way into OUT so the strobe lines up with OUT.
      result_valid_q <= mac_done;
      if (mac_done) result_q <= result_d;
      if (bus.sample_valid && busy) overrun_q <= 1'b1;
    end
  end

  // ---------------- Coefficient update capture ----------------
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      upd_en_q     <= 1'b0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      upd_en_q <= bus.update_en;
      // A fresh edge wins over (and replaces) any write still waiting for IDLE.
      if (upd_edge) begin
        pend_q.bank  <= bus.update_bank;
        pend_q.tap   <= bus.update_index;
        pend_q.value <= bus.update_value;
        pend_valid_q <= 1'b1;
      end else if (wr_en) begin
        pend_valid_q <= 1'b0;
      end
    end
  end

  assign bus.result_out   = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.busy         = busy;
  assign bus.overrun      = overrun_q;
  assign state_o          = state_q;

endmodule
